// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline.
//   It produces the enable/flush controls for the PC, IF/ID, ID/EX, EX/MEM
//   and MEM/WB registers from three conditions:
//     - memory handshake freeze
//     - load-use hazard
//     - EX-stage redirect
//   It also keeps a RUN/WAIT memory-wait FSM, a stall watchdog and
//   saturating performance counters.
//
// Ports
//   CLK, rst                    clock, asynchronous active-high reset
//   imem_req/imem_resp          IF fetch outstanding / fetch data valid
//   dmem_req/dmem_resp          MEM access outstanding / access complete
//   idex_mem_read, idex_rd      load in EX and its destination register
//   ifid_rs1/rs2, ifid_uses_*   source registers of ID and whether each is read
//   br_taken_ex                 EX resolved a taken branch/jump
//   perf_clr                    synchronous clear of counters and timeout flag
//   pc_en .. memwb_en           pipeline register enables (combinational)
//   ifid_flush, idex_flush      pipeline register flushes (combinational)
//   mem_wait                    FSM is in WAIT (registered)
//   stall_timeout               sticky watchdog flag
//   mem_stall_cnt, bubble_cnt,  saturating event counters
//   flush_cnt
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic             br_taken_ex,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_wait,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int LEN_W = $clog2(TIMEOUT) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_TRIP = LEN_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] stall_len;
    logic             freeze;
    logic             load_use;
    logic             take_redirect;
    logic             take_bubble;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (v >= LEN_MAX) ? LEN_MAX : v + LEN_W'(1);
    endfunction

    // A response in the same cycle as the request completes the access.
    assign freeze = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);

    // x0 is never a real dependency.
    assign load_use = idex_mem_read & (idex_rd != 5'd0) &
                      ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                       (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

    // While frozen, EX holds, so a pending redirect stays asserted and is
    // applied once on the first unfrozen cycle.
    assign take_redirect = ~freeze & br_taken_ex;
    assign take_bubble   = ~freeze & ~br_taken_ex & load_use;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (br_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (freeze)  state <= ST_WAIT;
                ST_WAIT: if (!freeze) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign mem_wait = (state == ST_WAIT);

    // Consecutive-freeze length; perf_clr deliberately does not touch it.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stall_len <= '0;
        end else if (freeze) begin
            stall_len <= len_sat_inc(stall_len);
        end else begin
            stall_len <= '0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stall_timeout <= 1'b0;
            mem_stall_cnt <= '0;
            bubble_cnt    <= '0;
            flush_cnt     <= '0;
        end else if (perf_clr) begin
            stall_timeout <= 1'b0;
            mem_stall_cnt <= '0;
            bubble_cnt    <= '0;
            flush_cnt     <= '0;
        end else begin
            if (freeze && stall_len == LEN_TRIP)
                stall_timeout <= 1'b1;
            if (freeze)
                mem_stall_cnt <= cnt_sat_inc(mem_stall_cnt);
            if (take_bubble)
                bubble_cnt <= cnt_sat_inc(bubble_cnt);
            if (take_redirect)
                flush_cnt <= cnt_sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control word: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] C_RUN = 7'b11111_00;
    localparam logic [6:0] C_FRZ = 7'b00000_00;
    localparam logic [6:0] C_RED = 7'b11111_11;
    localparam logic [6:0] C_LU  = 7'b00111_01;

    logic CLK, rst;
    logic imem_req, imem_resp, dmem_req, dmem_resp;
    logic idex_mem_read;
    logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
    logic ifid_uses_rs1, ifid_uses_rs2, br_taken_ex, perf_clr;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic mem_wait, stall_timeout;
    logic [CNT_W-1:0] mem_stall_cnt, bubble_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
        .CLK(CLK), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .br_taken_ex(br_taken_ex), .perf_clr(perf_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_wait(mem_wait), .stall_timeout(stall_timeout),
        .mem_stall_cnt(mem_stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [6:0] ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int ms, input int bu, input int fl);
        chk({tag, ".mem_stall_cnt"}, 32'(mem_stall_cnt), 32'(ms));
        chk({tag, ".bubble_cnt"},    32'(bubble_cnt),    32'(bu));
        chk({tag, ".flush_cnt"},     32'(flush_cnt),     32'(fl));
    endtask

    initial begin
        rst = 1'b1;
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; br_taken_ex = 0; perf_clr = 0;

        // Reset state
        #12;
        chk("rst.ctrl", 32'(ctrl()), 32'(C_RUN));
        chk("rst.mem_wait", 32'(mem_wait), 0);
        chk("rst.timeout", 32'(stall_timeout), 0);
        chk_cnts("rst", 0, 0, 0);
        rst = 1'b0;
        tick();

        // Load-use on rs1
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_uses_rs1 = 1;
        #1 chk("lu_rs1.ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        chk_cnts("lu_rs1", 0, 1, 0);

        // Same match but rd = x0: no hazard
        idex_rd = 0; ifid_rs1 = 0;
        #1 chk("lu_x0.ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        chk("lu_x0.bubble", 32'(bubble_cnt), 1);

        // Load-use on rs2 only
        idex_rd = 7; ifid_rs1 = 5; ifid_uses_rs1 = 1; ifid_rs2 = 7; ifid_uses_rs2 = 1;
        #1 chk("lu_rs2.ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        chk("lu_rs2.bubble", 32'(bubble_cnt), 2);

        // rs2 matches but is not read
        ifid_uses_rs2 = 0;
        #1 chk("lu_nouse.ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        chk("lu_nouse.bubble", 32'(bubble_cnt), 2);

        // Redirect overrides load-use
        ifid_uses_rs2 = 1; br_taken_ex = 1;
        #1 chk("red_lu.ctrl", 32'(ctrl()), 32'(C_RED));
        tick();
        chk_cnts("red_lu", 0, 2, 1);
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; br_taken_ex = 0;

        // dmem freeze for 3 cycles
        dmem_req = 1; dmem_resp = 0;
        #1 chk("dfrz1.ctrl", 32'(ctrl()), 32'(C_FRZ));
        chk("dfrz1.mem_wait", 32'(mem_wait), 0);
        tick();
        chk("dfrz1.mem_wait_after", 32'(mem_wait), 1);
        chk("dfrz2.ctrl", 32'(ctrl()), 32'(C_FRZ));
        tick();
        chk("dfrz3.ctrl", 32'(ctrl()), 32'(C_FRZ));
        tick();
        chk("dfrz3.mem_wait", 32'(mem_wait), 1);
        chk("dfrz3.timeout", 32'(stall_timeout), 0);
        chk("dfrz3.mem_stall", 32'(mem_stall_cnt), 3);
        // Response arrives with request still up: not a freeze
        dmem_resp = 1;
        #1 chk("dresp.ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        chk("dresp.mem_wait", 32'(mem_wait), 0);
        chk_cnts("dresp", 3, 2, 1);
        dmem_req = 0; dmem_resp = 0;

        // Redirect held through a 3-cycle imem freeze
        imem_req = 1; imem_resp = 0; br_taken_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("brfrz%0d.ctrl", i), 32'(ctrl()), 32'(C_FRZ));
            tick();
        end
        chk_cnts("brfrz", 6, 2, 1);
        imem_resp = 1;
        #1 chk("brrel.ctrl", 32'(ctrl()), 32'(C_RED));
        tick();
        chk_cnts("brrel", 6, 2, 2);
        imem_req = 0; imem_resp = 0; br_taken_ex = 0;
        #1 chk("brdone.ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        chk("brdone.flush", 32'(flush_cnt), 2);

        // Watchdog: 4 consecutive frozen cycles
        dmem_req = 1; dmem_resp = 0;
        tick(); tick(); tick();
        chk("wd3.timeout", 32'(stall_timeout), 0);
        tick();
        chk("wd4.timeout", 32'(stall_timeout), 1);
        chk("wd4.mem_stall", 32'(mem_stall_cnt), 10);
        // Keep freezing so mem_stall_cnt saturates at 15
        for (int i = 0; i < 6; i++) tick();
        chk("sat.mem_stall", 32'(mem_stall_cnt), 15);
        dmem_req = 0;
        tick();
        chk("wd_sticky.timeout", 32'(stall_timeout), 1);
        chk("wd_sticky.mem_stall", 32'(mem_stall_cnt), 15);
        chk("wd_sticky.mem_wait", 32'(mem_wait), 0);

        // perf_clr wins over an increment in the same cycle; FSM unaffected
        perf_clr = 1; dmem_req = 1;
        tick();
        chk("pclr.timeout", 32'(stall_timeout), 0);
        chk_cnts("pclr", 0, 0, 0);
        chk("pclr.mem_wait", 32'(mem_wait), 1);
        perf_clr = 0;
        tick();
        chk("post_pclr.mem_stall", 32'(mem_stall_cnt), 1);
        chk("post_pclr.mem_wait", 32'(mem_wait), 1);

        // Asynchronous reset in WAIT
        #2 rst = 1;
        #1 chk("arst.mem_wait", 32'(mem_wait), 0);
        chk_cnts("arst", 0, 0, 0);
        chk("arst.ctrl", 32'(ctrl()), 32'(C_FRZ));
        dmem_req = 0;
        #1 chk("arst.ctrl_run", 32'(ctrl()), 32'(C_RUN));
        #2 rst = 0;
        tick();
        chk("rel.ctrl", 32'(ctrl()), 32'(C_RUN));
        chk("rel.mem_wait", 32'(mem_wait), 0);
        chk("rel.mem_stall", 32'(mem_stall_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
